// File: rtl/apb_slave_mux.sv
// ---------------------------------------------------------------------------
// apb_slave_mux
//   Shares the bridge's single APB master port among NUM_SLV APB slaves.
//   paddr[SEL_LSB+3:SEL_LSB] selects the slave. psel is a combinational decode.
//   prdata/pready/pslverr of the selected slave are muxed back to the bridge.
//   A per-transfer watchdog forces an error completion after TIMEOUT stalled
//   ACCESS cycles. TIMEOUT=0 disables the watchdog.
//
// Ports
//   hclk, hreset_n  clock and asynchronous active-low reset
//   psel_en         bridge select (transfer active)
//   penable         bridge enable (ACCESS phase)
//   paddr           bridge address, stable for the whole transfer
//   psel            one-hot slave select (combinational)
//   prdata_s        slave read data, slave i at [i*PDATA_W +: PDATA_W]
//   pready_s        per-slave ready
//   pslverr_s       per-slave error
//   prdata          muxed read data to the bridge
//   pready_x        muxed or forced ready to the bridge
//   pslverr_x       muxed or forced error to the bridge
//   to_flag         sticky watchdog-timeout flag
//   to_idx          slave index of the last timeout
//   to_clr          synchronous clear of to_flag (clear wins over set)
//   state_dbg       FSM state (0 = IDLE, 1 = ACCESS)
//
// Handshake: a transfer is one setup cycle (psel_en=1, penable=0) followed by
// ACCESS cycles (psel_en=1, penable=1). The transfer completes in the ACCESS
// cycle where pready_x=1, and pslverr_x/prdata are meaningful only in that
// cycle. Dropping psel_en during ACCESS abandons the transfer silently.
// ---------------------------------------------------------------------------
module apb_slave_mux #(
  parameter int NUM_SLV = 4,
  parameter int PADDR_W = 16,
  parameter int PDATA_W = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic                       psel_en,
  input  logic                       penable,
  input  logic [PADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]         psel,
  input  logic [NUM_SLV*PDATA_W-1:0] prdata_s,
  input  logic [NUM_SLV-1:0]         pready_s,
  input  logic [NUM_SLV-1:0]         pslverr_s,
  output logic [PDATA_W-1:0]         prdata,
  output logic                       pready_x,
  output logic                       pslverr_x,
  output logic                       to_flag,
  output logic [3:0]                 to_idx,
  input  logic                       to_clr,
  output logic                       state_dbg
);

  // A zero-width counter is illegal, so the counter keeps one bit when the
  // watchdog is off. It then never leaves zero.
  localparam int          CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_nxt;
  logic [3:0]         cur_idx, cur_idx_nxt;
  logic               cur_map, cur_map_nxt;
  logic               to_hit;

  // Address decode
  logic [3:0] idx;
  logic       mapped;
  logic       paddr_unused;

  assign idx          = paddr[SEL_LSB+3:SEL_LSB];
  assign mapped       = ({1'b0, idx} < 5'(NUM_SLV));
  assign paddr_unused = ^paddr;
  assign state_dbg    = state;

  // The target slave's response, selected by the index latched at setup
  logic [PDATA_W-1:0] sel_rdata;
  logic               sel_ready;
  logic               sel_err;

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cur_idx == 4'(i)) begin
        sel_rdata = prdata_s[i*PDATA_W +: PDATA_W];
        sel_ready = pready_s[i];
        sel_err   = pslverr_s[i];
      end
    end
  end

  // State register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cur_idx  <= '0;
      cur_map  <= 1'b0;
      to_flag  <= 1'b0;
      to_idx   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      cur_idx  <= cur_idx_nxt;
      cur_map  <= cur_map_nxt;
      if (to_clr) begin
        to_flag <= 1'b0;
      end else if (to_hit) begin
        to_flag <= 1'b1;
      end
      if (to_hit) begin
        to_idx <= cur_idx;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    cur_idx_nxt = cur_idx;
    cur_map_nxt = cur_map;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        // penable without a preceding setup is ignored
        if (psel_en && !penable) begin
          state_nxt   = ACCESS;
          cur_idx_nxt = idx;
          cur_map_nxt = mapped;
          wait_nxt    = '0;
        end
      end
      ACCESS: begin
        if (!psel_en) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (penable) begin
          if (!cur_map || sel_ready) begin
            // A slave answering on the watchdog's last cycle still wins
            state_nxt = IDLE;
          end else if (TO_EN && (wait_cnt == TO_CNT)) begin
            state_nxt = IDLE;
            to_hit    = 1'b1;
          end else if (wait_cnt != TO_CNT) begin
            wait_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    psel      = '0;
    pready_x  = 1'b0;
    pslverr_x = 1'b0;
    prdata    = '0;
    // psel is gated by reset so that it drops while reset is held mid-transfer
    if (hreset_n && psel_en && mapped) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        psel[i] = (idx == 4'(i));
      end
    end
    if (state == ACCESS && cur_map) begin
      prdata = sel_rdata;
    end
    if (state == ACCESS && psel_en && penable) begin
      if (!cur_map) begin
        pready_x  = 1'b1;
        pslverr_x = 1'b1;
      end else if (sel_ready) begin
        pready_x  = 1'b1;
        pslverr_x = sel_err;
      end else if (TO_EN && (wait_cnt == TO_CNT)) begin
        pready_x  = 1'b1;
        pslverr_x = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mux.sv
module tb_apb_slave_mux;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            hclk;
  logic            hreset_n;
  logic            psel_en;
  logic            penable;
  logic [15:0]     paddr;
  logic [NS-1:0]   psel;
  logic [NS*DW-1:0] prdata_s;
  logic [NS-1:0]   pready_s;
  logic [NS-1:0]   pslverr_s;
  logic [DW-1:0]   prdata;
  logic            pready_x;
  logic            pslverr_x;
  logic            to_flag;
  logic [3:0]      to_idx;
  logic            to_clr;
  logic            state_dbg;

  int vectors = 0;
  int miscompares = 0;
  bit rand_clr = 0;
  bit clr_hold = 0;

  apb_slave_mux #(
    .NUM_SLV(NS), .PADDR_W(16), .PDATA_W(DW), .SEL_LSB(12), .TIMEOUT(TMO)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .psel_en(psel_en), .penable(penable),
    .paddr(paddr), .psel(psel), .prdata_s(prdata_s), .pready_s(pready_s),
    .pslverr_s(pslverr_s), .prdata(prdata), .pready_x(pready_x),
    .pslverr_x(pslverr_x), .to_flag(to_flag), .to_idx(to_idx),
    .to_clr(to_clr), .state_dbg(state_dbg)
  );

  // Clock
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: a transfer is "open" after its setup
  // cycle, and completes in access cycle n when the slave is ready, when the
  // target is unmapped, or when n reaches TMO+1.
  bit        m_busy;
  int        m_idx;
  bit        m_map;
  int        m_acc;
  bit        m_flag;
  int        m_toidx;

  always @(negedge hclk) begin
    logic [3:0]  a_idx;
    logic [3:0]  e_psel;
    logic        e_rdy, e_err, e_to;
    logic [31:0] e_rd;
    int          n;
    a_idx = paddr[15:12];
    if (!hreset_n) begin
      m_busy = 0; m_idx = 0; m_map = 0; m_acc = 0; m_flag = 0; m_toidx = 0;
      chk("rst_psel", 32'(psel), 0);
      chk("rst_pready", 32'(pready_x), 0);
      chk("rst_pslverr", 32'(pslverr_x), 0);
      chk("rst_prdata", prdata, 0);
      chk("rst_to_flag", 32'(to_flag), 0);
      chk("rst_to_idx", 32'(to_idx), 0);
    end else begin
      e_psel = '0;
      if (psel_en && int'(a_idx) < NS) e_psel[a_idx[1:0]] = 1'b1;
      e_rdy = 0; e_err = 0; e_to = 0;
      n = m_acc + 1;
      if (m_busy && psel_en && penable) begin
        if (!m_map) begin
          e_rdy = 1; e_err = 1;
        end else if (pready_s[m_idx]) begin
          e_rdy = 1; e_err = pslverr_s[m_idx];
        end else if (n == TMO + 1) begin
          e_rdy = 1; e_err = 1; e_to = 1;
        end
      end
      e_rd = (m_busy && m_map) ? prdata_s[m_idx*DW +: DW] : 32'h0;
      chk("psel", 32'(psel), 32'(e_psel));
      chk("pready_x", 32'(pready_x), 32'(e_rdy));
      chk("pslverr_x", 32'(pslverr_x), 32'(e_err));
      chk("prdata", prdata, e_rd);
      chk("to_flag", 32'(to_flag), 32'(m_flag));
      chk("to_idx", 32'(to_idx), 32'(m_toidx));
      chk("state_dbg", 32'(state_dbg), 32'(m_busy));
      // advance the model to the next edge (inputs are stable until then)
      if (!m_busy) begin
        if (psel_en && !penable) begin
          m_busy = 1; m_idx = int'(a_idx); m_map = (int'(a_idx) < NS); m_acc = 0;
        end
      end else if (!psel_en) begin
        m_busy = 0;
      end else if (penable) begin
        if (e_rdy) m_busy = 0;
        else m_acc = n;
      end
      if (to_clr) m_flag = 0;
      else if (e_to) m_flag = 1;
      if (e_to) m_toidx = m_idx;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic noise();
    pready_s  = 4'($urandom);
    pslverr_s = 4'($urandom);
    for (int i = 0; i < NS; i++) prdata_s[i*DW +: DW] = $urandom;
    to_clr = rand_clr ? ($urandom_range(0, 15) == 0) : clr_hold;
  endtask

  task automatic idle(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      step();
      noise();
      r = $urandom_range(0, 7);
      psel_en = (r == 0);
      penable = (r <= 1);
      paddr   = 16'($urandom);
    end
  endtask

  // stall < 0: target never ready. abort_at > 0: drop psel_en before that access cycle.
  task automatic do_xfer(input logic [15:0] addr, input int stall, input logic err,
                         input logic [31:0] data, input int abort_at,
                         output int ncyc, output logic oerr, output logic [31:0] ordata,
                         output logic [3:0] opsel);
    int tgt;
    int k;
    bit done;
    tgt = int'(addr[15:12]);
    ncyc = 0; oerr = 0; ordata = 0; opsel = 0; done = 0;
    step();
    noise();
    psel_en = 1; penable = 0; paddr = addr;
    #1 opsel = psel;
    k = 1;
    while (!done && k <= 20) begin
      step();
      noise();
      if (abort_at == k) begin
        psel_en = 0; penable = 0;
        return;
      end
      penable = 1;
      if (tgt < NS) begin
        pready_s[tgt]  = (stall < 0) ? 1'b0 : (k > stall);
        pslverr_s[tgt] = err;
        prdata_s[tgt*DW +: DW] = data;
      end
      @(negedge hclk);
      if (pready_x) begin
        done = 1; ncyc = k; oerr = pslverr_x; ordata = prdata;
      end
      k++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL xfer_done: no pready_x within 20 access cycles, addr %h", addr);
      step();
      psel_en = 0; penable = 0;
    end
  endtask

  // Stimulus
  initial begin
    int          nc;
    logic        oe;
    logic [31:0] od;
    logic [3:0]  op;
    logic [15:0] a;
    int          st;
    int          ab;

    hreset_n = 0; psel_en = 0; penable = 0; paddr = 0; to_clr = 0;
    pready_s = 0; pslverr_s = 0; prdata_s = '0;
    step();
    step();
    psel_en = 1; penable = 1; paddr = 16'h2000;
    #1 chk("rst_psel_gated", 32'(psel), 0);
    psel_en = 0; penable = 0;
    step();
    hreset_n = 1;
    idle(2);

    // 1: write to slave 2, ready immediately
    do_xfer(16'h2004, 0, 1'b0, 32'h0, 0, nc, oe, od, op);
    chk("t1_psel", 32'(op), 32'h4);
    chk("t1_cycles", nc, 1);
    chk("t1_err", 32'(oe), 0);

    // 2: read from slave 1 with 3 stall cycles
    do_xfer(16'h1010, 3, 1'b0, 32'hDEADBEEF, 0, nc, oe, od, op);
    chk("t2_cycles", nc, 4);
    chk("t2_prdata", od, 32'hDEADBEEF);
    idle(1);

    // 3: unmapped slave 5
    do_xfer(16'h5000, 0, 1'b0, 32'h0, 0, nc, oe, od, op);
    chk("t3_psel", 32'(op), 0);
    chk("t3_cycles", nc, 1);
    chk("t3_err", 32'(oe), 1);
    chk("t3_prdata", od, 0);

    // 5: slave error, then back-to-back read to slave 1
    do_xfer(16'h0000, 0, 1'b1, 32'h0, 0, nc, oe, od, op);
    chk("t5_err", 32'(oe), 1);
    do_xfer(16'h1008, 0, 1'b0, 32'h12345678, 0, nc, oe, od, op);
    chk("t5_b2b_cycles", nc, 1);
    chk("t5_b2b_err", 32'(oe), 0);
    chk("t5_b2b_prdata", od, 32'h12345678);
    chk("t5_to_flag", 32'(to_flag), 0);

    // slave ready in the watchdog's last cycle wins
    do_xfer(16'h2000, 8, 1'b0, 32'hA5A5A5A5, 0, nc, oe, od, op);
    chk("edge_cycles", nc, 9);
    chk("edge_err", 32'(oe), 0);
    idle(1);
    chk("edge_to_flag", 32'(to_flag), 0);

    // 4: slave 3 never ready -> forced completion in access cycle 9
    do_xfer(16'h3000, -1, 1'b0, 32'h0, 0, nc, oe, od, op);
    chk("t4_cycles", nc, 9);
    chk("t4_err", 32'(oe), 1);
    idle(1);
    chk("t4_to_flag", 32'(to_flag), 1);
    chk("t4_to_idx", 32'(to_idx), 3);
    step();
    to_clr = 1;
    step();
    to_clr = 0;
    chk("t4_clr", 32'(to_flag), 0);

    // timeout with clear held: flag stays 0, index still updates
    clr_hold = 1;
    do_xfer(16'h1000, -1, 1'b0, 32'h0, 0, nc, oe, od, op);
    chk("clr_cycles", nc, 9);
    idle(1);
    chk("clr_to_flag", 32'(to_flag), 0);
    chk("clr_to_idx", 32'(to_idx), 1);
    clr_hold = 0;
    idle(1);

    // 6: reset in access cycle 2 of a stalled transfer
    step();
    pready_s = 0; to_clr = 0;
    psel_en = 1; penable = 0; paddr = 16'h3000;
    step();
    penable = 1;
    step();
    hreset_n = 0;
    #1;
    chk("t6_psel", 32'(psel), 0);
    chk("t6_pready", 32'(pready_x), 0);
    chk("t6_pslverr", 32'(pslverr_x), 0);
    step();
    psel_en = 0; penable = 0;
    step();
    hreset_n = 1;
    do_xfer(16'h1000, 1, 1'b0, 32'hCAFEF00D, 0, nc, oe, od, op);
    chk("t6_after_cycles", nc, 2);
    chk("t6_after_prdata", od, 32'hCAFEF00D);

    // randomized traffic
    rand_clr = 1;
    for (int t = 0; t < 300; t++) begin
      a  = {4'($urandom_range(0, 5)), 12'($urandom)};
      st = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 10);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      do_xfer(a, st, 1'($urandom), $urandom, ab, nc, oe, od, op);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_clr = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
